// File: rtl/dm_sized_ws.sv
// Byte-addressed little-endian data memory with sized loads/stores and programmable wait states.
// Optional alignment checking is compiled in with DM_ALIGN_CHECK_EN.
module dm_sized_ws #(
  parameter int    ADDR_W    = 9,
  parameter int    WAIT_CYC  = 1,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int         DEPTH   = 1 << ADDR_W;
  localparam bit         NO_WAIT = (WAIT_CYC == 0);
  localparam logic [3:0] LAST    = 4'((WAIT_CYC == 0) ? 0 : WAIT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [7:0]        mem [DEPTH];

  // With no wait states the commit happens on the accept edge, so live inputs are used.
  logic              acc_we, acc_sext, bad, commit;
  logic [1:0]        acc_size;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata, raw, fmt;
  logic [ADDR_W-1:0] lane_a [4];

  always_comb begin
    if (state_q == S_IDLE) begin
      acc_we = we; acc_size = size; acc_sext = sext; acc_addr = addr; acc_wdata = wdata;
    end else begin
      acc_we = we_q; acc_size = size_q; acc_sext = sext_q; acc_addr = addr_q; acc_wdata = wdata_q;
    end
    for (int k = 0; k < 4; k++) lane_a[k] = acc_addr + ADDR_W'(k);
  end

  always_comb begin
    bad = (acc_size == 2'b11);
`ifdef DM_ALIGN_CHECK_EN
    if ((acc_size == 2'b01 && acc_addr[0]) || (acc_size == 2'b10 && acc_addr[1:0] != 2'b00))
      bad = 1'b1;
`endif
    commit = rstn && ((state_q == S_WAIT && cnt_q == LAST) ||
                      (NO_WAIT && state_q == S_IDLE && req));
  end

  always_comb begin
    raw = {mem[lane_a[3]], mem[lane_a[2]], mem[lane_a[1]], mem[lane_a[0]]};
    case (acc_size)
      2'b00:   fmt = {{24{acc_sext & raw[7]}}, raw[7:0]};
      2'b01:   fmt = {{16{acc_sext & raw[15]}}, raw[15:0]};
      default: fmt = raw;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: if (req) begin
        we_d    = we;
        size_d  = size;
        sext_d  = sext;
        addr_d  = addr;
        wdata_d = wdata;
        cnt_d   = 4'd0;
        state_d = NO_WAIT ? S_RESP : S_WAIT;
      end
      S_WAIT: if (cnt_q == LAST) begin
        cnt_d   = 4'd0;
        state_d = S_RESP;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
    if (commit) begin
      err_d = bad;
      if (!acc_we) rdata_d = bad ? 32'd0 : fmt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM is deliberately outside the reset domain so contents survive rstn.
  always_ff @(posedge clk) begin
    if (commit && acc_we && !bad) begin
      mem[lane_a[0]] <= acc_wdata[7:0];
      if (acc_size != 2'b00) mem[lane_a[1]] <= acc_wdata[15:8];
      if (acc_size == 2'b10) begin
        mem[lane_a[2]] <= acc_wdata[23:16];
        mem[lane_a[3]] <= acc_wdata[31:24];
      end
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign rvalid = (state_q == S_RESP);
  assign rdata  = rdata_q;
  assign err    = err_q;

endmodule

// File: tb/tb_dm_sized_ws.sv
// Scoreboard bench for dm_sized_ws: instances with WAIT_CYC = 1, 3 and 0 driven through one access task.
module tb_dm_sized_ws;

  logic        clk;
  logic        rstn_v  [3];
  logic        req_v   [3];
  logic        we_v    [3];
  logic [1:0]  size_v  [3];
  logic        sext_v  [3];
  logic [8:0]  addr_v  [3];
  logic [31:0] wdata_v [3];
  logic        ready_v [3];
  logic        rvalid_v[3];
  logic [31:0] rdata_v [3];
  logic        err_v   [3];

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [31:0] rd;
    logic        er;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0]  ref_mem [3][512];
  logic [31:0] last_rd [3];
  logic [31:0] last_obs;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dm_sized_ws #(.ADDR_W(9), .WAIT_CYC(1)) u_dut_w1 (
    .clk(clk), .rstn(rstn_v[0]), .req(req_v[0]), .we(we_v[0]), .size(size_v[0]),
    .sext(sext_v[0]), .addr(addr_v[0]), .wdata(wdata_v[0]), .ready(ready_v[0]),
    .rvalid(rvalid_v[0]), .rdata(rdata_v[0]), .err(err_v[0]));

  dm_sized_ws #(.ADDR_W(9), .WAIT_CYC(3)) u_dut_w3 (
    .clk(clk), .rstn(rstn_v[1]), .req(req_v[1]), .we(we_v[1]), .size(size_v[1]),
    .sext(sext_v[1]), .addr(addr_v[1]), .wdata(wdata_v[1]), .ready(ready_v[1]),
    .rvalid(rvalid_v[1]), .rdata(rdata_v[1]), .err(err_v[1]));

  dm_sized_ws #(.ADDR_W(9), .WAIT_CYC(0)) u_dut_w0 (
    .clk(clk), .rstn(rstn_v[2]), .req(req_v[2]), .we(we_v[2]), .size(size_v[2]),
    .sext(sext_v[2]), .addr(addr_v[2]), .wdata(wdata_v[2]), .ready(ready_v[2]),
    .rvalid(rvalid_v[2]), .rdata(rdata_v[2]), .err(err_v[2]));

  function automatic int wc(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference memory behaviour: little-endian lanes with 9-bit wrap.
  task automatic model(input int d, input bit w, input logic [1:0] sz, input bit sx,
                       input logic [8:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
    int          nb;
    logic [8:0]  ba;
    logic [31:0] raw;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    er = (sz == 2'b11);
`ifdef DM_ALIGN_CHECK_EN
    if ((sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)) er = 1'b1;
`endif
    if (w) begin
      if (!er)
        for (int k = 0; k < nb; k++) begin
          ba = a + 9'(k);
          ref_mem[d][ba] = wd[8*k +: 8];
        end
      rd = last_rd[d];
    end else begin
      raw = 32'd0;
      if (!er) begin
        for (int k = 0; k < nb; k++) begin
          ba = a + 9'(k);
          raw[8*k +: 8] = ref_mem[d][ba];
        end
        if (sx && sz == 2'b00 && raw[7])  raw[31:8]  = 24'hFFFFFF;
        if (sx && sz == 2'b01 && raw[15]) raw[31:16] = 16'hFFFF;
      end
      rd = raw;
      last_rd[d] = rd;
    end
  endtask

  task automatic do_acc(input int d, input bit w, input logic [1:0] sz, input bit sx,
                        input logic [8:0] a, input logic [31:0] wd, input bit hold);
    exp_t        e;
    int          lat;
    bit          done;
    logic [31:0] erd;
    logic        eer;
    model(d, w, sz, sx, a, wd, erd, eer);
    e.rd = erd;
    e.er = eer;
    exp_q.push_back(e);
    @(negedge clk);
    chk("ready_idle", 32'(ready_v[d]), 32'd1);
    req_v[d] = 1'b1; we_v[d] = w; size_v[d] = sz; sext_v[d] = sx; addr_v[d] = a; wdata_v[d] = wd;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (!hold) req_v[d] = 1'b0;
      if (rvalid_v[d]) begin
        done = 1'b1;
        req_v[d] = 1'b0;
      end else begin
        chk("busy_ready", 32'(ready_v[d]), 32'd0);
      end
    end
    chk("resp_seen", 32'(done), 32'd1);
    chk("latency", 32'(lat), 32'(wc(d) + 1));
    e = exp_q.pop_front();
    chk("rdata", rdata_v[d], e.rd);
    chk("err", 32'(err_v[d]), 32'(e.er));
    chk("resp_ready", 32'(ready_v[d]), 32'd0);
    last_obs = rdata_v[d];
    @(posedge clk);
    #1;
    chk("pulse_end", 32'(rvalid_v[d]), 32'd0);
    chk("ready_back", 32'(ready_v[d]), 32'd1);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rstn_v[d] = 1'b0; req_v[d] = 1'b0; we_v[d] = 1'b0; size_v[d] = 2'b00;
      sext_v[d] = 1'b0; addr_v[d] = 9'd0; wdata_v[d] = 32'd0; last_rd[d] = 32'd0;
    end
    last_obs = 32'd0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_ready", 32'(ready_v[d]), 32'd1);
      chk("rst_rvalid", 32'(rvalid_v[d]), 32'd0);
      chk("rst_rdata", rdata_v[d], 32'd0);
      chk("rst_err", 32'(err_v[d]), 32'd0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) rstn_v[d] = 1'b1;

    // Word store/load, sign/zero-extended sub-word loads, byte merge.
    do_acc(0, 1, 2'b10, 0, 9'h010, 32'h8765_4321, 0);
    do_acc(0, 0, 2'b10, 0, 9'h010, 32'd0, 0);
    chk("t1_word", last_obs, 32'h8765_4321);
    do_acc(0, 0, 2'b00, 1, 9'h013, 32'd0, 0);
    chk("t2_byte_sext", last_obs, 32'hFFFF_FF87);
    do_acc(0, 0, 2'b01, 0, 9'h012, 32'd0, 0);
    chk("t2_half_zext", last_obs, 32'h0000_8765);
    do_acc(0, 1, 2'b00, 0, 9'h011, 32'hDEAD_BEAA, 0);
    chk("store_keeps_rdata", last_obs, 32'h0000_8765);
    do_acc(0, 0, 2'b10, 0, 9'h010, 32'd0, 0);
    chk("t3_merge", last_obs, 32'h8765_AA21);

    // Top-of-memory wrap, or rejection when alignment checking is built in.
    do_acc(0, 1, 2'b00, 0, 9'h1FF, 32'h0000_005A, 0);
    do_acc(0, 1, 2'b00, 0, 9'h000, 32'h0000_00A5, 0);
    do_acc(0, 1, 2'b10, 0, 9'h1FF, 32'h1122_3344, 0);
    do_acc(0, 0, 2'b00, 0, 9'h1FF, 32'd0, 0);
`ifdef DM_ALIGN_CHECK_EN
    chk("t4_b1ff", last_obs, 32'h0000_005A);
`else
    chk("t4_b1ff", last_obs, 32'h0000_0044);
`endif
    do_acc(0, 0, 2'b00, 0, 9'h000, 32'd0, 0);
`ifdef DM_ALIGN_CHECK_EN
    chk("t4_b000", last_obs, 32'h0000_00A5);
`else
    chk("t4_b000", last_obs, 32'h0000_0033);
`endif
    do_acc(0, 0, 2'b01, 1, 9'h1FF, 32'd0, 0);

    // Reserved size with req held through the wait state.
    do_acc(0, 0, 2'b11, 0, 9'h010, 32'd0, 1);
    chk("t5_rsvd_rdata", last_obs, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("t5_no_dup", 32'(rvalid_v[0]), 32'd0);
    end

    // Randomised traffic over a pre-filled window.
    for (int i = 0; i < 16; i++) do_acc(0, 1, 2'b10, 0, 9'(9'h100 + 4 * i), $urandom, 0);
    for (int i = 0; i < 24; i++)
      do_acc(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             9'(9'h100 + $urandom_range(0, 59)), $urandom, 0);

    // Reset abort mid-wait on the three-wait-state instance.
    do_acc(1, 1, 2'b00, 0, 9'h020, 32'h0000_005C, 0);
    do_acc(1, 0, 2'b00, 0, 9'h020, 32'd0, 0);
    @(negedge clk);
    req_v[1] = 1'b1; we_v[1] = 1'b1; size_v[1] = 2'b00; addr_v[1] = 9'h020; wdata_v[1] = 32'h0000_00E7;
    @(posedge clk);
    #1;
    req_v[1] = 1'b0;
    @(posedge clk);
    #2;
    rstn_v[1] = 1'b0;
    #1;
    chk("t6_rst_ready", 32'(ready_v[1]), 32'd1);
    chk("t6_rst_rvalid", 32'(rvalid_v[1]), 32'd0);
    chk("t6_rst_rdata", rdata_v[1], 32'd0);
    last_rd[1] = 32'd0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rstn_v[1] = 1'b1;
    do_acc(1, 0, 2'b00, 0, 9'h020, 32'd0, 0);
    chk("t6_abort_kept", last_obs, 32'h0000_005C);

    // Zero wait states.
    do_acc(2, 1, 2'b10, 0, 9'h040, 32'hCAFE_F00D, 0);
    do_acc(2, 0, 2'b10, 0, 9'h040, 32'd0, 0);
    chk("w0_word", last_obs, 32'hCAFE_F00D);
    do_acc(2, 0, 2'b01, 1, 9'h042, 32'd0, 0);
    chk("w0_half_sext", last_obs, 32'hFFFF_CAFE);
    do_acc(2, 1, 2'b01, 0, 9'h041, 32'h0000_1234, 0);
    do_acc(2, 0, 2'b10, 0, 9'h040, 32'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
